// File: rtl/mult_seq_approx_pkg.sv
// rtl/mult_seq_approx_pkg.sv - shared types and helpers for the approximate sequential multiplier
package mult_approx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    // The trunc field must be able to express 0..2*width, plus headroom for out-of-range requests.
    function automatic int trunc_width(input int width);
        return $clog2(2 * width) + 1;
    endfunction

    function automatic int clamp_trunc(input int width, input int trunc);
        return (trunc > 2 * width) ? 2 * width : trunc;
    endfunction

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_TW    = trunc_width(DEFAULT_WIDTH);

endpackage

// File: rtl/mult_seq_approx_if.sv
// rtl/mult_seq_approx_if.sv - operand and product valid/ready channels of the multiplier
interface mult_seq_approx_if
    import mult_approx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int TW    = trunc_width(WIDTH)
);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [TW-1:0]        in_trunc;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;
    logic [TW-1:0]        out_trunc;

    modport master (
        output in_valid,
        input  in_ready,
        output in_a,
        output in_b,
        output in_trunc,
        input  out_valid,
        output out_ready,
        input  out_p,
        input  out_trunc
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_a,
        input  in_b,
        input  in_trunc,
        output out_valid,
        input  out_ready,
        output out_p,
        output out_trunc
    );

endinterface

// File: rtl/mult_seq_approx_pp_col_mask.sv
// rtl/mult_seq_approx_pp_col_mask.sv - trunc value to result-column keep mask
module pp_col_mask
    import mult_approx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int TW    = trunc_width(WIDTH)
) (
    input  logic [TW-1:0]        trunc,
    output logic [2*WIDTH-1:0]   mask
);

    // Column j survives when j >= trunc; trunc >= 2*WIDTH clears every column.
    for (genvar j = 0; j < 2 * WIDTH; j++) begin : g_col
        localparam logic [TW-1:0] COL = TW'(j);
        assign mask[j] = (COL >= trunc);
    end

endmodule

// File: rtl/mult_seq_approx.sv
// rtl/mult_seq_approx.sv - iterative shift-add multiplier with run-time low-column truncation
module mult_seq_approx
    import mult_approx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int TW    = trunc_width(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    mult_seq_approx_if.slave  bus
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    mult_state_e        state_q;
    mult_state_e        state_d;

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [TW-1:0]      trunc_q;
    logic [CW-1:0]      cnt_q;
    logic [PW-1:0]      acc_q;

    logic [PW-1:0]      out_p_q;
    logic [TW-1:0]      out_trunc_q;
    logic               out_valid_q;

    logic [PW-1:0]      col_mask;
    logic [PW-1:0]      pp;
    logic               accept;
    logic               step;
    logic               load_out;
    logic               handshake;

    pp_col_mask #(
        .WIDTH (WIDTH),
        .TW    (TW)
    ) u_col_mask (
        .trunc (trunc_q),
        .mask  (col_mask)
    );

    always_comb begin
        pp = '0;
        if (b_q[cnt_q]) begin
            pp = {{WIDTH{1'b0}}, a_q} << cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DONE spends its first cycle loading the output registers, then waits for the handshake.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        step      = 1'b0;
        load_out  = 1'b0;
        handshake = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!out_valid_q) begin
                    load_out = 1'b1;
                end else if (bus.out_ready) begin
                    handshake = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            trunc_q <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else if (accept) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            trunc_q <= TW'(clamp_trunc(WIDTH, int'(bus.in_trunc)));
            cnt_q   <= '0;
            acc_q   <= '0;
        end else if (step) begin
            acc_q   <= acc_q + (pp & col_mask);
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p_q     <= '0;
            out_trunc_q <= '0;
            out_valid_q <= 1'b0;
        end else if (load_out) begin
            out_p_q     <= acc_q;
            out_trunc_q <= trunc_q;
            out_valid_q <= 1'b1;
        end else if (handshake) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;
    assign bus.out_trunc = out_trunc_q;

endmodule

// File: tb/tb_mult_seq_approx.sv
// tb/tb_mult_seq_approx.sv - scoreboard bench for mult_seq_approx
module tb_mult_seq_approx;
    import mult_approx_pkg::*;

    localparam int WIDTH = 16;
    localparam int TW    = trunc_width(WIDTH);
    localparam int PW    = 2 * WIDTH;
    localparam int LAT   = WIDTH + 1;

    typedef struct packed {
        logic [PW-1:0] p;
        logic [TW-1:0] t;
        logic [PW-1:0] exact;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    mult_seq_approx_if #(.WIDTH(WIDTH)) bus();

    mult_seq_approx #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] ref_mult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input int t);
        logic [PW-1:0] mask;
        logic [PW-1:0] acc;
        int tc;
        tc   = (t > PW) ? PW : t;
        mask = '1;
        mask = mask << tc;
        acc  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i]) acc = acc + ((PW'(a) << i) & mask);
        end
        return acc;
    endfunction

    // Called just after a rising edge with the DUT idle.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [TW-1:0] t, input int hold, input bit early);
        exp_t e;
        int lat;
        logic [PW-1:0] p0;
        logic [TW-1:0] t0;
        expect_eq("idle_ready", 64'(bus.in_ready), 64'd1);
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_trunc  = t;
        bus.in_valid  = 1'b1;
        bus.out_ready = early;
        e.p     = ref_mult(a, b, int'(t));
        e.t     = (int'(t) > PW) ? TW'(PW) : t;
        e.exact = PW'(a) * PW'(b);
        sb.push_back(e);
        @(posedge clk); #1;
        // Scramble inputs and keep in_valid up: both must be ignored while busy.
        bus.in_a     = WIDTH'($urandom);
        bus.in_b     = WIDTH'($urandom);
        bus.in_trunc = TW'($urandom_range(0, 63));
        lat = 0;
        do begin
            expect_eq("busy_ready", 64'(bus.in_ready), 64'd0);
            @(posedge clk); #1;
            lat++;
        end while (!bus.out_valid && lat < LAT + 4);
        expect_eq("latency", 64'(lat), 64'(LAT));
        bus.in_valid = 1'b0;
        if (!bus.out_valid) begin
            bus.out_ready = 1'b0;
            void'(sb.pop_front());
            return;
        end
        p0 = bus.out_p;
        t0 = bus.out_trunc;
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                expect_eq("hold_valid", 64'(bus.out_valid), 64'd1);
                expect_eq("hold_p", 64'(bus.out_p), 64'(p0));
                expect_eq("hold_trunc", 64'(bus.out_trunc), 64'(t0));
                expect_eq("hold_ready", 64'(bus.in_ready), 64'd0);
            end
            bus.out_ready = 1'b1;
        end
        e = sb.pop_front();
        expect_eq("out_p", 64'(bus.out_p), 64'(e.p));
        expect_eq("out_trunc", 64'(bus.out_trunc), 64'(e.t));
        expect_eq("approx_le_exact", 64'(bus.out_p <= e.exact), 64'd1);
        @(posedge clk); #1;
        expect_eq("post_valid", 64'(bus.out_valid), 64'd0);
        expect_eq("post_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_trunc  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        expect_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        expect_eq("rst_out_p", 64'(bus.out_p), 64'd0);
        expect_eq("rst_out_trunc", 64'(bus.out_trunc), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(16'd3, 16'd5, 6'd0, 0, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 6'd0, 0, 1'b1);
        do_op(16'h00FF, 16'h0101, 6'd8, 0, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 6'd40, 0, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 6'd32, 0, 1'b1);
        do_op(16'h1234, 16'h5678, 6'd5, 5, 1'b0);
        do_op(16'h0000, 16'hFFFF, 6'd0, 1, 1'b0);
        do_op(16'hABCD, 16'h0000, 6'd3, 0, 1'b1);
        do_op(16'h8000, 16'h8000, 6'd30, 2, 1'b0);

        // Abort an operation at step 7; nothing from it may surface.
        bus.in_a     = 16'hFFFF;
        bus.in_b     = 16'hFFFF;
        bus.in_trunc = 6'd0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expect_eq("abort_out_valid", 64'(bus.out_valid), 64'd0);
        expect_eq("abort_in_ready", 64'(bus.in_ready), 64'd1);
        expect_eq("abort_out_p", 64'(bus.out_p), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_eq("abort_idle_valid", 64'(bus.out_valid), 64'd0);
        do_op(16'd2, 16'd2, 6'd0, 0, 1'b0);

        for (int i = 0; i < 2500; i++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), TW'($urandom_range(0, 40)),
                  int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        expect_eq("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
